// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Provides the RISC-V funct3 operation encodings, the FSM state encodings
// and the default parameter values used by muldiv_unit and muldiv_step.
package muldiv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 5;

    // RV32M/RV64M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div_i  1        : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i     2*XLEN   : accumulator before the step
//                        multiply: partial product
//                        divide  : {partial remainder, quotient bits so far}
//   opd_i     XLEN     : multiplicand (multiply) or divisor (divide)
//   bit_i     1        : next multiplier bit (MSB first) or next dividend bit
//   acc_o     2*XLEN   : accumulator after the step
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opd_i,
    input  logic              bit_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     rem_sh;
    logic              q_bit;
    logic [XLEN-1:0]   rem_new;

    always_comb begin
        // MSB-first shift-add: acc = 2*acc + (bit ? multiplicand : 0)
        mul_acc = {acc_i[2*XLEN-2:0], 1'b0} + (bit_i ? {{XLEN{1'b0}}, opd_i} : {2*XLEN{1'b0}});

        // Bring the next dividend bit into the partial remainder. The shifted
        // remainder is below 2*divisor, so when the subtract succeeds the
        // difference always fits back into XLEN bits.
        rem_sh  = {acc_i[2*XLEN-1:XLEN], bit_i};
        q_bit   = (rem_sh >= {1'b0, opd_i});
        rem_new = q_bit ? XLEN'(rem_sh - {1'b0, opd_i}) : rem_sh[XLEN-1:0];

        if (is_div_i) begin
            acc_o = {rem_new, acc_i[XLEN-2:0], q_bit};
        end else begin
            acc_o = mul_acc;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit, one result bit per cycle.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   kill                : synchronous abort of any in-flight operation
//   in_valid/in_ready   : request handshake (ready only while idle)
//   in_op[2:0]          : funct3 operation code
//   in_a, in_b [XLEN]   : rs1 / rs2 operands
//   in_tag [TAG_W]      : destination tag, returned unchanged
//   out_valid/out_ready : response handshake
//   out_result [XLEN]   : result
//   out_tag [TAG_W]     : tag of the returned result
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_PREP = ST_PREP;
    localparam logic [2:0] S_CALC = ST_CALC;
    localparam logic [2:0] S_FIX  = ST_FIX;
    localparam logic [2:0] S_DONE = ST_DONE;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

    logic [2:0]        state_q,  state_d;
    muldiv_op_e        op_q,     op_d;
    logic [XLEN-1:0]   opd_q,    opd_d;     // raw rs1 until PREP, then multiplicand/divisor
    logic [XLEN-1:0]   src_q,    src_d;     // raw rs2 until PREP, then bit source shifted MSB first
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic              neg_q,    neg_d;     // sign of the selected result
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, is_rem, sgn_a, sgn_b, sa, sb;
    logic [XLEN-1:0]   abs_a, abs_b, quo, rem;
    logic [2*XLEN-1:0] prod, step_acc;

    assign is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign is_rem = op_q inside {OP_REM, OP_REMU};

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (op_q)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            OP_MULHSU: sgn_a = 1'b1;
            default:   ;
        endcase
    end

    // Sign/magnitude of the operands as latched in IDLE (valid during PREP)
    assign sa    = sgn_a & opd_q[XLEN-1];
    assign sb    = sgn_b & src_q[XLEN-1];
    assign abs_a = sa ? neg_x(opd_q) : opd_q;
    assign abs_b = sb ? neg_x(src_q) : src_q;

    // Fix-up values (valid during FIX); neg_q already holds the op-specific sign
    assign prod = neg_q ? neg_2x(acc_q) : acc_q;
    assign quo  = neg_q ? neg_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign rem  = neg_q ? neg_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .bit_i    (src_q[XLEN-1]),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opd_d    = opd_q;
        src_d    = src_q;
        tag_d    = tag_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d    = muldiv_op_e'(in_op);
                        opd_d   = in_a;
                        src_d   = in_b;
                        tag_d   = in_tag;
                        state_d = S_PREP;
                    end
                end
                S_PREP: begin
                    acc_d = '0;
                    cnt_d = CNT_W'(XLEN);
                    if (is_div) begin
                        neg_d = is_rem ? sa : (sa ^ sb);
                        opd_d = abs_b;
                        src_d = abs_a;
                    end else begin
                        neg_d = sa ^ sb;
                        opd_d = abs_a;
                        src_d = abs_b;
                    end
                    if (is_div && (src_q == '0)) begin
                        result_d = is_rem ? opd_q : '1;
                        state_d  = S_DONE;
                    end else if (is_div && sgn_a && (opd_q == MOST_NEG) && (src_q == '1)) begin
                        result_d = is_rem ? '0 : opd_q;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
                S_CALC: begin
                    acc_d = step_acc;
                    src_d = {src_q[XLEN-2:0], 1'b0};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    case (op_q)
                        OP_MUL:                      result_d = prod[XLEN-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
                        OP_DIV, OP_DIVU:             result_d = quo;
                        default:                     result_d = rem;
                    endcase
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            opd_q    <= '0;
            src_q    <= '0;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opd_q    <= opd_d;
            src_q    <= src_d;
            tag_q    <= tag_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the RISC-V core. It sits beside the single-cycle ALU in the datapath. The core hands it one operation at a time over a valid/ready request channel and collects the result and destination tag over a valid/ready response channel. Width is generic in XLEN. It produces one result bit per cycle and handles every architecturally defined corner case.

## Interface
Parameters:
- XLEN, 32 — operand/result width (32 or 64).
- TAG_W, 5 — width of the passthrough destination tag (rd index).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- kill  in  1  synchronous abort of any in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- in_op  in  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  XLEN  rs1 operand (multiplicand / dividend).
- in_b  in  XLEN  rs2 operand (multiplier / divisor).
- in_tag  in  TAG_W  destination tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the returned result.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, the unit latches op, operands and tag, then goes to PREP.
  - Inputs are ignored after the accepting edge.
- PREP:
  - Record the result sign.
  - Take absolute values of signed operands: both for MULH, DIV and REM; only a for MULHSU.
  - Clear the 2·XLEN accumulator and load the bit counter with XLEN.
  - Special cases go straight to DONE with the result loaded:
    - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
    - Signed overflow (DIV/REM with a = most-negative value and b = −1): DIV gives a; REM gives 0.
  - All other cases go to CALC.
- CALC:
  - Runs exactly XLEN cycles.
  - Multiply: shift-add radix-2 into a 2·XLEN product.
  - Divide: restoring shift-subtract, yielding XLEN-bit quotient and remainder.
  - Counter reaches 0, then FIX.
- FIX:
  - Apply two's-complement negation if the sign is negative.
  - Multiply negation is over the full 2·XLEN bits.
  - Divide: the quotient takes sign(a) xor sign(b); the remainder takes sign(a).
  - Select the result:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV*: quotient.
    - REM*: remainder.
  - Go to DONE.
- DONE:
  - out_valid=1; out_result and out_tag are held stable.
  - On out_ready, go to IDLE.
  - There is no request acceptance in the same cycle; in_ready rises after that edge.
- kill:
  - Highest priority below reset.
  - Any state goes to IDLE on the next edge, out_valid=0, and no result is produced.
  - kill with in_valid in IDLE drops the request.

## Timing
- Reset values: in_ready=1, out_valid=0, out_result=0, out_tag=0. State goes to IDLE and the internal accumulator/counter are cleared.
- Request accepted at edge E0. Normal path: out_valid is high after edge E0+XLEN+2 (34 for XLEN=32).
- Special-case path: out_valid is high after edge E0+1.
- The result stays valid indefinitely under backpressure; in_ready stays 0 for the whole busy period.
- Reset asserted mid-operation aborts immediately (asynchronous). The unit resumes in IDLE with reset values.
- Throughput: one operation per XLEN+3 cycles at best (plus 1 for the DONE-to-IDLE return).

## Structure
- The shared defines package gets:
  - muldiv_op_e enum (the funct3 encodings above).
  - muldiv_state_e enum.
  - Defaults XLEN_DEF=32 and TAG_W_DEF=5.
- One sub-module is natural: muldiv_step. It is combinational and performs one iteration, either a shift-add step or a restore-subtract step, selected by is_div. It is instantiated once inside the CALC datapath.
- Everything else (FSM, operand/sign registers, counter, fix-up) lives in muldiv_unit.

## Test plan
(XLEN=32)
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → 0xFFFFFFEB, tag echoed, out_valid after edge E0+34.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF; DIVU 100/7 → 14 and REMU → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0; all with out_valid after edge E0+1.
- out_ready held low 5 cycles in DONE → out_result/out_tag stable and in_ready=0 throughout; after the handshake, in_ready=1 on the next cycle and a back-to-back request is accepted.
- kill during CALC cycle 10 → out_valid never rises and in_ready=1 after the next edge. Async reset mid-CALC → outputs at reset values immediately, and the next request completes correctly.
